atomic_mem_responder: RTL

//  Data-memory responder for the ipu load/store port: serves LOAD, STORE, LR and SC with a

---
 rtl/atomic_mem_responder_if.sv | 22 ++
 rtl/atomic_mem_responder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/atomic_mem_responder_if.sv
// Request/response handshake between the ipu load/store port (master) and the
// data-memory responder (slave).
interface atomic_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/atomic_mem_responder.sv
// Word-array responder for LOAD/STORE/LR/SC with fixed wait states and one LR reservation.
// Optional macro RSV_TIMEOUT_EN: the reservation expires RSV_TIMEOUT cycles after LR commit.
module atomic_mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int RSV_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    atomic_mem_responder_if.slave  bus,
    output logic                   rsv_valid_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'd0, OP_STORE = 2'd1, OP_LR = 2'd2, OP_SC = 2'd3} op_t;

    state_t                 state, state_nxt;
    logic [3:0]             wait_cnt;
    op_t                    op_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rsp_rdata_q;
    logic                   rsv_valid;
    logic [ADDR_BITS-1:0]   rsv_addr;
    logic [31:0]            mem [2**ADDR_BITS];

    logic                   accept, commit, rsv_live, rsv_hit, mem_we;
    op_t                    c_op;
    logic [ADDR_BITS-1:0]   c_idx;
    logic [31:0]            c_wdata;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{bus.req_addr[31:ADDR_BITS+2], bus.req_addr[1:0]};

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        accept        = 1'b0;
        commit        = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        commit    = 1'b1;
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A zero-wait commit happens on the accept edge, so it must use the live request fields.
    assign c_op    = (state == S_IDLE) ? op_t'(bus.req_op) : op_q;
    assign c_idx   = (state == S_IDLE) ? bus.req_addr[ADDR_BITS+1:2] : idx_q;
    assign c_wdata = (state == S_IDLE) ? bus.req_wdata : wdata_q;

`ifdef RSV_TIMEOUT_EN
    logic [31:0] rsv_cnt;
    // The edge on which the lifetime counter reaches 0 already counts as expired.
    assign rsv_live = rsv_valid && (rsv_cnt != 32'd1);
`else
    localparam int unused_rsv_timeout = RSV_TIMEOUT;
    assign rsv_live = rsv_valid;
`endif

    assign rsv_hit     = rsv_live && (rsv_addr == c_idx);
    assign mem_we      = commit && reset && ((c_op == OP_STORE) || (c_op == OP_SC && rsv_hit));
    assign rsv_valid_o = rsv_valid;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            rsp_rdata_q <= 32'd0;
            rsv_valid   <= 1'b0;
`ifdef RSV_TIMEOUT_EN
            rsv_cnt     <= 32'd0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) wait_cnt <= 4'(WAIT_CYCLES);
            else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;

            if (commit) begin
                case (c_op)
                    OP_LOAD, OP_LR: rsp_rdata_q <= mem[c_idx];
                    OP_STORE:       rsp_rdata_q <= 32'd0;
                    default:        rsp_rdata_q <= {31'd0, ~rsv_hit};
                endcase
            end

            if (commit && c_op == OP_LR) rsv_valid <= 1'b1;
            else if (commit && (c_op == OP_SC || (c_op == OP_STORE && rsv_addr == c_idx)))
                rsv_valid <= 1'b0;
            else if (rsv_valid && !rsv_live) rsv_valid <= 1'b0;

`ifdef RSV_TIMEOUT_EN
            if (commit && c_op == OP_LR) rsv_cnt <= 32'(RSV_TIMEOUT);
            else if (rsv_valid && rsv_cnt != 32'd0) rsv_cnt <= rsv_cnt - 32'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op_t'(bus.req_op);
            idx_q   <= bus.req_addr[ADDR_BITS+1:2];
            wdata_q <= bus.req_wdata;
        end
        if (commit && c_op == OP_LR) rsv_addr <= c_idx;
        if (mem_we) mem[c_idx] <= c_wdata;
    end
endmodule
